// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
package regfile_pkg;

    localparam int unsigned RF_NREGS  = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

    // One pending regfile write: destination register and result data.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_bypass_match.sv
// Newest-first associative match of a read address against the valid
// entries of the writeback queue (head through head+count-1).
module rf_wb_bypass_match
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  rf_wb_entry_t         entries [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [CNT_W-1:0]     count,
    input  logic [RF_ADDR_W-1:0] raddr,
    output logic                 hit_c,
    output logic [RF_DATA_W-1:0] data_c
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest; a later (younger) match overrides an older one.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        idx    = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = PTR_W'(32'(head) + i);
            if (i < 32'(count) && entries[idx].addr == raddr) begin
                hit_c  = 1'b1;
                data_c = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the regfile's single write port, with
// read-side bypass so decode always sees the newest queued value.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [RF_ADDR_W-1:0] in_waddr,
    input  logic [RF_DATA_W-1:0] in_wdata,
    input  logic                 rf_wgrant,
    output logic                 rf_wen,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,
    input  logic [RF_ADDR_W-1:0] rd_raddr,
    input  logic [RF_DATA_W-1:0] rf_rdata,
    output logic [RF_DATA_W-1:0] rd_data,
    output logic                 rd_hit,
    output logic [CNT_W-1:0]     count
);

    rf_wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic                 enq_c;
    logic                 store_c;
    logic                 deq_c;
    logic [CNT_W-1:0]     count_nxt_c;
    logic                 match_hit_c;
    logic [RF_DATA_W-1:0] match_data_c;

    // Handshake completes even for x0; only nonzero destinations are stored.
    assign enq_c   = in_val && in_rdy;
    assign store_c = enq_c && (in_waddr != '0);
    assign deq_c   = (count != '0) && rf_wgrant;

    // Occupancy after this edge.
    always_comb begin
        count_nxt_c = count;
        if (store_c && !deq_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (deq_c && !store_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and the registered ready; wrap is natural (DEPTH = 2^k).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            in_rdy <= 1'b0;
        end else begin
            if (store_c) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq_c) begin
                head <= head + PTR_W'(1);
            end
            count  <= count_nxt_c;
            in_rdy <= (count_nxt_c != CNT_W'(DEPTH));
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem[tail] <= rf_wb_entry_t'{addr: in_waddr, data: in_wdata};
        end
    end

    assign rf_wen   = deq_c;
    assign rf_waddr = (count != '0) ? mem[head].addr : '0;
    assign rf_wdata = (count != '0) ? mem[head].data : '0;

    rf_wb_bypass_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries (mem),
        .head    (head),
        .count   (count),
        .raddr   (rd_raddr),
        .hit_c   (match_hit_c),
        .data_c  (match_data_c)
    );

    // x0 always reads zero; otherwise prefer the youngest queued value.
    assign rd_hit  = (rd_raddr != '0) && match_hit_c;
    assign rd_data = (rd_raddr == '0) ? '0 :
                     match_hit_c      ? match_data_c : rf_rdata;

endmodule
